// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the round-robin forwarding mux pipe.
//   clog2    : ceiling log2 usable in parameter expressions
//   ptrw_of  : FIFO pointer width (one extra wrap bit over the address)
//   cw_of    : occupancy counter width, holds 0..DEPTH
//   rr_pick  : round-robin selection starting after the last grant
package mux_pipe_pkg;

    localparam int MAXCH = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ptrw_of(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int cw_of(input int depth);
        return clog2(depth + 1);
    endfunction

    // Scans last+1, last+2, ... modulo nchan. Walking the offsets from the
    // far end down lets the nearest eligible channel overwrite the result,
    // so no early exit is needed.
    function automatic rr_t rr_pick(input logic [MAXCH-1:0] elig,
                                    input logic [2:0]       last,
                                    input int               nchan);
        rr_t r;
        int  c;
        r = '0;
        for (int k = nchan; k >= 1; k--) begin
            c = (int'(last) + k) % nchan;
            if (elig[c[2:0]]) begin
                r.valid = 1'b1;
                r.idx   = c[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_pipe_rr_fifo_n.sv
// Circular-buffer FIFO used for each forward channel.
//   CLK, RST                  : clock, synchronous active-high reset
//   enq__ENA / enq_v / RDY    : write port, RDY = not full
//   deq__ENA / deq__RDY       : read port, RDY = not empty
//   first                     : head entry (valid when deq__RDY)
//   count                     : occupancy 0..DEPTH
module fifo_n
    import mux_pipe_pkg::*;
#(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 4,
    localparam int PTRW  = ptrw_of(DEPTH),
    localparam int CW    = cw_of(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enq__ENA,
    input  logic [WIDTH-1:0] enq_v,
    output logic             enq__RDY,
    input  logic             deq__ENA,
    output logic             deq__RDY,
    output logic [WIDTH-1:0] first,
    output logic [CW-1:0]    count
);

    localparam int AW = PTRW - 1;

    logic [PTRW-1:0]  rptr_q, rptr_d;
    logic [PTRW-1:0]  wptr_q, wptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, empty, do_enq, do_deq;

    // Pointers carry one wrap bit: same address with differing wrap bits is full.
    assign full   = (rptr_q[PTRW-1] != wptr_q[PTRW-1]) && (rptr_q[AW-1:0] == wptr_q[AW-1:0]);
    assign empty  = (rptr_q == wptr_q);
    assign do_enq = enq__ENA && !full;
    assign do_deq = deq__ENA && !empty;

    always_comb begin
        rptr_d = rptr_q + PTRW'(do_deq);
        wptr_d = wptr_q + PTRW'(do_enq);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_enq && !RST) mem_q[wptr_q[AW-1:0]] <= enq_v;
    end

    assign enq__RDY = !full;
    assign deq__RDY = !empty;
    assign first    = mem_q[rptr_q[AW-1:0]];
    assign count    = CW'(wptr_q - rptr_q);

endmodule

// File: rtl/mux_pipe_rr.sv
// Merges NCHAN buffered forward channels and one unbuffered direct channel
// into a single enq-style output. Forward FIFOs are served round-robin;
// IN_PRIO selects whether the direct channel (1) or the FIFOs (0) win.
//   CLK, RST           : clock, synchronous active-high reset
//   in_enq_*           : direct channel, zero-latency path to the output
//   forward_enq_*      : per-channel FIFO writes, channel i at [i*WIDTH +: WIDTH]
//   forward_count      : per-channel occupancy, CW bits each
//   out_enq_*          : merged output towards the shared consumer
module mux_pipe_rr
    import mux_pipe_pkg::*;
#(
    parameter  int WIDTH   = 128,
    parameter  int DEPTH   = 4,
    parameter  int NCHAN   = 2,
    parameter  int IN_PRIO = 0,
    localparam int CW      = cw_of(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_enq__ENA,
    input  logic [WIDTH-1:0]       in_enq_v,
    output logic                   in_enq__RDY,
    input  logic [NCHAN-1:0]       forward_enq__ENA,
    input  logic [NCHAN*WIDTH-1:0] forward_enq_v,
    output logic [NCHAN-1:0]       forward_enq__RDY,
    output logic [NCHAN*CW-1:0]    forward_count,
    output logic                   out_enq__ENA,
    output logic [WIDTH-1:0]       out_enq_v,
    input  logic                   out_enq__RDY
);

    logic [NCHAN-1:0] fifo_enq_rdy;
    logic [NCHAN-1:0] fifo_deq_rdy;
    logic [NCHAN-1:0] fifo_deq;
    logic [WIDTH-1:0] fifo_first [NCHAN];
    logic [CW-1:0]    fifo_count [NCHAN];

    logic [2:0]       last_grant_q, last_grant_d;
    logic [MAXCH-1:0] elig;
    rr_t              pick;
    logic             fwd_go;
    logic             in_rdy;
    logic [WIDTH-1:0] head;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        fifo_n #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .CLK      (CLK),
            .RST      (RST),
            .enq__ENA (forward_enq__ENA[i]),
            .enq_v    (forward_enq_v[i*WIDTH +: WIDTH]),
            .enq__RDY (fifo_enq_rdy[i]),
            .deq__ENA (fifo_deq[i]),
            .deq__RDY (fifo_deq_rdy[i]),
            .first    (fifo_first[i]),
            .count    (fifo_count[i])
        );

        assign forward_count[i*CW +: CW] = RST ? '0 : fifo_count[i];
    end

    always_comb begin
        elig            = '0;
        elig[NCHAN-1:0] = fifo_deq_rdy;
        pick            = rr_pick(elig, last_grant_q, NCHAN);

        // With direct priority the forward grant yields to a pending direct
        // strobe, giving a combinational direct ENA -> output ENA path.
        if (IN_PRIO == 0) begin
            in_rdy = !RST && out_enq__RDY && !pick.valid;
            fwd_go = !RST && out_enq__RDY && pick.valid;
        end else begin
            in_rdy = !RST && out_enq__RDY;
            fwd_go = !RST && out_enq__RDY && pick.valid && !in_enq__ENA;
        end

        head     = '0;
        fifo_deq = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (pick.idx == 3'(i)) begin
                head        = fifo_first[i];
                fifo_deq[i] = fwd_go;
            end
        end

        last_grant_d = fwd_go ? pick.idx : last_grant_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) last_grant_q <= 3'(NCHAN - 1);
        else     last_grant_q <= last_grant_d;
    end

    assign in_enq__RDY      = in_rdy;
    assign forward_enq__RDY = RST ? '0 : fifo_enq_rdy;
    assign out_enq__ENA     = fwd_go || (in_enq__ENA && in_rdy);
    assign out_enq_v        = fwd_go ? head : in_enq_v;

endmodule

// File: tb/tb_mux_pipe_rr.sv
module tb_mux_pipe_rr;

    localparam int W  = 128;
    localparam int D  = 4;
    localparam int N  = 2;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_ena0, in_ena1;
    logic [W-1:0]   in_v;
    logic [N-1:0]   fwd_ena;
    logic [N*W-1:0] fwd_v;
    logic           out_rdy;

    logic           in_rdy0, in_rdy1;
    logic [N-1:0]   fwd_rdy0, fwd_rdy1;
    logic [N*CW-1:0] cnt0, cnt1;
    logic           oena0, oena1;
    logic [W-1:0]   ov0, ov1;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp0 [$];
    logic [W-1:0] exp1 [$];

    always #5 clk = ~clk;

    mux_pipe_rr #(.WIDTH(W), .DEPTH(D), .NCHAN(N), .IN_PRIO(0)) dut0 (
        .CLK              (clk),
        .RST              (rst),
        .in_enq__ENA      (in_ena0),
        .in_enq_v         (in_v),
        .in_enq__RDY      (in_rdy0),
        .forward_enq__ENA (fwd_ena),
        .forward_enq_v    (fwd_v),
        .forward_enq__RDY (fwd_rdy0),
        .forward_count    (cnt0),
        .out_enq__ENA     (oena0),
        .out_enq_v        (ov0),
        .out_enq__RDY     (out_rdy)
    );

    mux_pipe_rr #(.WIDTH(W), .DEPTH(D), .NCHAN(N), .IN_PRIO(1)) dut1 (
        .CLK              (clk),
        .RST              (rst),
        .in_enq__ENA      (in_ena1),
        .in_enq_v         (in_v),
        .in_enq__RDY      (in_rdy1),
        .forward_enq__ENA (fwd_ena),
        .forward_enq_v    (fwd_v),
        .forward_enq__RDY (fwd_rdy1),
        .forward_count    (cnt1),
        .out_enq__ENA     (oena1),
        .out_enq_v        (ov1),
        .out_enq__RDY     (out_rdy)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] mkw(input logic [31:0] t);
        return {~t, t ^ 32'h5A5A_5A5A, t, t + 32'h1};
    endfunction

    task automatic push2(input logic [W-1:0] v);
        exp0.push_back(v);
        exp1.push_back(v);
    endtask

    // Scoreboard: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (oena0) begin
            chk("out0_pending", W'(exp0.size() != 0), W'(1));
            if (exp0.size() != 0) chk("out0_data", ov0, exp0.pop_front());
        end
        if (oena1) begin
            chk("out1_pending", W'(exp1.size() != 0), W'(1));
            if (exp1.size() != 0) chk("out1_data", ov1, exp1.pop_front());
        end
    end

    initial begin
        rst = 1'b1; in_ena0 = 1'b0; in_ena1 = 1'b0; in_v = '0;
        fwd_ena = '0; fwd_v = '0; out_rdy = 1'b1;

        // reset and idle
        nxt();
        neg();
        chk("rst_fwd_rdy", W'(fwd_rdy0), W'(0));
        chk("rst_in_rdy", W'(in_rdy0), W'(0));
        chk("rst_out_ena", W'(oena0), W'(0));
        nxt();
        rst = 1'b0;
        neg();
        chk("idle_fwd_rdy", W'(fwd_rdy0), W'(2'b11));
        chk("idle_in_rdy", W'(in_rdy0), W'(1));
        chk("idle_out_ena", W'(oena0), W'(0));
        chk("idle_count", W'(cnt0), W'(0));

        // round-robin: channel 0 first after reset
        nxt();
        out_rdy = 1'b0;
        fwd_ena = 2'b11;
        fwd_v   = {mkw(32'hB0), mkw(32'hA0)};
        nxt();
        fwd_v   = {mkw(32'hB1), mkw(32'hA1)};
        nxt();
        fwd_ena = '0;
        push2(mkw(32'hA0)); push2(mkw(32'hB0)); push2(mkw(32'hA1)); push2(mkw(32'hB1));
        out_rdy = 1'b1;
        repeat (4) begin
            neg();
            chk("rr_out_ena", W'(oena0), W'(1));
            nxt();
        end
        neg();
        chk("rr_idle", W'(oena0), W'(0));
        chk("rr_last_grant", W'(dut0.last_grant_q), W'(1));

        // fill to full, ignored 5th write, then drain in order
        nxt();
        out_rdy = 1'b0;
        fwd_ena = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            fwd_v = {W'(0), mkw(32'(k))};
            push2(mkw(32'(k)));
            nxt();
            chk("fill_count", W'(cnt0[CW-1:0]), W'(k));
        end
        chk("full_rdy0", W'(fwd_rdy0[0]), W'(0));
        chk("full_rdy1", W'(fwd_rdy0[1]), W'(1));
        fwd_v = {W'(0), mkw(32'd5)};
        nxt();
        chk("full_ignored", W'(cnt0[CW-1:0]), W'(4));
        fwd_ena = '0;
        out_rdy = 1'b1;
        repeat (4) begin
            neg();
            chk("drain_out_ena", W'(oena0), W'(1));
            nxt();
        end
        chk("drain_count", W'(cnt0[CW-1:0]), W'(0));

        // priority: same stimulus, opposite order on the two variants
        out_rdy = 1'b0;
        fwd_ena = 2'b10;
        fwd_v   = {mkw(32'h55), W'(0)};
        nxt();
        fwd_ena = '0;
        exp0.push_back(mkw(32'h55)); exp0.push_back(mkw(32'hAA));
        exp1.push_back(mkw(32'hAA)); exp1.push_back(mkw(32'h55));
        out_rdy = 1'b1;
        in_ena0 = 1'b1; in_ena1 = 1'b1; in_v = mkw(32'hAA);
        neg();
        chk("prio0_in_rdy", W'(in_rdy0), W'(0));
        chk("prio1_in_rdy", W'(in_rdy1), W'(1));
        nxt();
        in_ena1 = 1'b0;
        neg();
        chk("prio0_in_rdy_next", W'(in_rdy0), W'(1));
        chk("prio1_count", W'(cnt1[2*CW-1:CW]), W'(1));
        nxt();
        in_ena0 = 1'b0;
        neg();
        chk("prio_done0", W'(oena0), W'(0));
        chk("prio_done1", W'(oena1), W'(0));

        // wrap with simultaneous enq/deq every cycle
        nxt();
        out_rdy = 1'b1;
        fwd_ena = 2'b01;
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] w;
            w = {$urandom(), $urandom(), $urandom(), 32'h1000 + 32'(i)};
            fwd_v = {W'(0), w};
            push2(w);
            neg();
            if (i > 0) begin
                chk("wrap_count", W'(cnt0[CW-1:0]), W'(1));
                chk("wrap_out_ena", W'(oena0), W'(1));
            end else begin
                chk("wrap_first_idle", W'(oena0), W'(0));
            end
            nxt();
        end
        fwd_ena = '0;
        neg();
        chk("wrap_last_out", W'(oena0), W'(1));
        nxt();
        neg();
        chk("wrap_drained", W'(cnt0[CW-1:0]), W'(0));

        // reset mid-stream discards buffered data
        nxt();
        out_rdy = 1'b0;
        fwd_ena = 2'b01;
        for (int k = 0; k < 3; k++) begin
            fwd_v = {W'(0), mkw(32'h770 + 32'(k))};
            nxt();
        end
        fwd_ena = '0;
        chk("pre_rst_count", W'(cnt0[CW-1:0]), W'(3));
        rst = 1'b1;
        out_rdy = 1'b1;
        neg();
        chk("mid_rst_out_ena0", W'(oena0), W'(0));
        chk("mid_rst_out_ena1", W'(oena1), W'(0));
        chk("mid_rst_count", W'(cnt0), W'(0));
        chk("mid_rst_in_rdy", W'(in_rdy0), W'(0));
        nxt();
        rst = 1'b0;
        neg();
        chk("post_rst_count", W'(cnt0), W'(0));
        chk("post_rst_out_ena", W'(oena0), W'(0));
        chk("post_rst_fwd_rdy", W'(fwd_rdy0), W'(2'b11));
        nxt();

        chk("sb_empty0", W'(exp0.size()), W'(0));
        chk("sb_empty1", W'(exp1.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_pipe_rr.md
Name: mux_pipe_rr

Overview:
- Parametrised successor of the single-entry forwarding mux pipe.
- Merges NCHAN buffered forward channels and one unbuffered direct channel into a single enq-style output.
- Each forward channel has its own DEPTH-entry FIFO. Forward FIFOs are served round-robin.
- A mode parameter fixes the priority between the direct channel and the forward channels. Sits between request sources and a shared downstream enq consumer.

Parameters:
- WIDTH, 128, payload width in bits (>=1)
- DEPTH, 4, entries per forward FIFO (power of 2, >=2)
- NCHAN, 2, number of forward channels (2..8)
- IN_PRIO, 0, 0 = forward FIFOs win over direct input; 1 = direct input wins

Ports:
- CLK  input  1  clock; all state on rising edge
- RST  input  1  reset, synchronous, active-high
- in$enq__ENA  input  1  direct-channel enqueue strobe
- in$enq$v  input  WIDTH  direct-channel payload
- in$enq__RDY  output  1  direct channel may enqueue this cycle
- forward$enq__ENA  input  NCHAN  per-channel enqueue strobe
- forward$enq$v  input  NCHAN*WIDTH  per-channel payload; channel i at [i*WIDTH +: WIDTH]
- forward$enq__RDY  output  NCHAN  per-channel not-full
- forward$count  output  NCHAN*CW  per-channel occupancy, CW = clog2(DEPTH+1)
- out$enq__ENA  output  1  output transfer strobe
- out$enq$v  output  WIDTH  output payload
- out$enq__RDY  input  1  downstream can accept

Behaviour:
- Reset (RST high at an edge):
  - all FIFO pointers and counts = 0
  - last_grant = NCHAN-1, so channel 0 is served first
- While RST is high, all __RDY outputs and out$enq__ENA are driven 0, and forward$count reads 0.
- Reset mid-operation discards all buffered data. No output is produced in the reset cycle.
- Protocol: a transfer occurs when ENA=1 in a cycle where the matching RDY=1. ENA with RDY=0 is a caller violation: it is ignored and flagged by a bench assertion.
- Forward FIFO i:
  - circular buffer with rptr/wptr of clog2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; empty = pointers equal
  - forward$enq__RDY[i] = !full_i
  - no bypass: data enqueued in cycle t is eligible for output no earlier than t+1
  - pointers wrap modulo 2*DEPTH
  - enq and deq in the same cycle are legal when not full; the count is unchanged
- Eligibility: elig[i] = !empty_i. anyfwd = OR(elig).
- Round-robin: the candidate is the first eligible channel scanning last_grant+1, last_grant+2, … modulo NCHAN.
- IN_PRIO=0:
  - fwd_go = out$enq__RDY & anyfwd
  - in$enq__RDY = out$enq__RDY & !anyfwd
- IN_PRIO=1:
  - in$enq__RDY = out$enq__RDY
  - fwd_go = out$enq__RDY & anyfwd & !in$enq__ENA (combinational ENA->ENA path is permitted)
- Output, all combinational from registered state and inputs:
  - out$enq__ENA = fwd_go | (in$enq__ENA & in$enq__RDY)
  - out$enq$v = FIFO head of the granted channel if fwd_go, else in$enq$v
- On fwd_go: the granted FIFO's rptr advances and last_grant <= granted index.
- last_grant is unchanged when no forward grant occurs, including direct-channel transfers.
- Latency: forward path 1 cycle minimum (enq edge to visible at head); direct path 0 cycles.
- Throughput: 1 output transfer per cycle.
- Fairness: with all NCHAN channels continuously non-empty and out$enq__RDY=1, each channel gets exactly 1 grant per NCHAN cycles.
- Width rules: forward$count is CW bits, range 0..DEPTH. Payload is never modified or truncated.

Decomposition:
- Package mux_pipe_pkg:
  - clog2 constant function
  - CW and PTRW derivations
  - rr_pick function (elig vector, last_grant) -> {valid, index}
- One sub-module fifo_n: parametrised WIDTH/DEPTH FIFO.
  - ports: enq ENA/v/RDY, deq ENA/RDY, first, count
  - instantiated NCHAN times via generate
- Arbitration and output mux stay in mux_pipe_rr.

Test Plan:
- Reset then idle, WIDTH=128, DEPTH=4, NCHAN=2: after RST deasserts, forward$enq__RDY=2'b11, in$enq__RDY=1, out$enq__ENA=0, counts 0. Assert RST mid-stream with 3 entries buffered: next cycle counts 0 and no output.
- Fill/full: enqueue 0x1,0x2,0x3,0x4 on ch0 with out$enq__RDY=0: count 1,2,3,4. forward$enq__RDY[0]=0 after the 4th; a 5th ENA is ignored. Raise out$enq__RDY: output 0x1..0x4 in order over 4 consecutive cycles, count returns to 0.
- Round-robin: preload ch0={A0,A1}, ch1={B0,B1}, out$enq__RDY=1: output order A0,B0,A1,B1. Then out$enq__ENA=0 and last_grant=1.
- Priority IN_PRIO=0: ch1 holds 0x55 while in$enq__ENA=1 with 0xAA: in$enq__RDY=0, output 0x55. Next cycle in$enq__RDY=1, output 0xAA.
- Priority IN_PRIO=1, same stimulus: output 0xAA first, ch1 count stays 1. Following cycle with in$enq__ENA=0: output 0x55.
- Wrap and concurrency, DEPTH=4: stream 20 words into ch0 with simultaneous enq/deq every cycle. Output sequence equals input sequence delayed 1 cycle; count held at 1; pointers wrap 2.5 times with no loss.
